// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory masters (fetch, load/store, DMA), the arbiter and u_mem.
// The slave modport is the arbiter's view; the master modport is the masters-plus-memory side.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

interface mem_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = `ADDR_W,
    parameter int DATA_W  = `XLEN
);
    logic [NUM_REQ-1:0]             m_req;
    logic [NUM_REQ-1:0]             m_lock;
    logic [NUM_REQ-1:0]             m_we;
    logic [NUM_REQ-1:0][3:0]        m_wstrb;
    logic [NUM_REQ-1:0][ADDR_W-1:0] m_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] m_wdata;
    logic [NUM_REQ-1:0]             m_gnt;
    logic [NUM_REQ-1:0]             m_rvalid;
    logic [DATA_W-1:0]              m_rdata;
    logic                           mem_en;
    logic                           mem_we;
    logic [3:0]                     mem_wstrb;
    logic [ADDR_W-1:0]              mem_addr;
    logic [DATA_W-1:0]              mem_wdata;
    logic [DATA_W-1:0]              mem_rdata;

    modport slave (
        input  m_req, m_lock, m_we, m_wstrb, m_addr, m_wdata, mem_rdata,
        output m_gnt, m_rvalid, m_rdata, mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata
    );

    modport master (
        output m_req, m_lock, m_we, m_wstrb, m_addr, m_wdata, mem_rdata,
        input  m_gnt, m_rvalid, m_rdata, mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin single-beat arbiter for u_mem with bounded lock and 1-cycle read return.
// Optional macro ARB_CONFLICT_CNT_EN adds a saturating 32-bit perf_conflict counter.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module mem_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int MAX_LOCK = 8,
    parameter int ADDR_W   = `ADDR_W,
    parameter int DATA_W   = `XLEN
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
`ifdef ARB_CONFLICT_CNT_EN
    ,
    output logic [31:0]   perf_conflict
`endif
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic {ARB, LOCKED} state_e;

    state_e             state_q;
    logic [IW-1:0]      rr_ptr_q, owner_q;
    logic [CW-1:0]      lock_cnt_q;
    logic [NUM_REQ-1:0] pend_q;

    logic [IW-1:0]      cand, win, sel;
    logic               any, gnt_ok;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
        return (int'(x) == NUM_REQ - 1) ? '0 : x + IW'(1);
    endfunction

    always_comb begin
        win  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!any && bus.m_req[cand]) begin
                any = 1'b1;
                win = cand;
            end
        end
    end

    // While locked only the owner can be granted; reset masks the grant combinationally.
    always_comb begin
        sel    = (state_q == LOCKED) ? owner_q : win;
        gnt_ok = ((state_q == LOCKED) ? bus.m_req[owner_q] : any) && !rst;
        bus.m_gnt = '0;
        if (gnt_ok) bus.m_gnt[sel] = 1'b1;
        bus.mem_en    = gnt_ok;
        bus.mem_we    = gnt_ok && bus.m_we[sel];
        bus.mem_wstrb = bus.m_wstrb[sel];
        bus.mem_addr  = bus.m_addr[sel];
        bus.mem_wdata = bus.m_wdata[sel];
    end

    assign bus.m_rvalid = pend_q;
    assign bus.m_rdata  = (pend_q != '0) ? bus.mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            pend_q     <= '0;
        end else begin
            pend_q <= (gnt_ok && !bus.m_we[sel]) ? bus.m_gnt : '0;
            case (state_q)
                ARB: if (any) begin
                    rr_ptr_q <= nxt(win);
                    if (bus.m_lock[win] && MAX_LOCK > 1) begin
                        owner_q    <= win;
                        lock_cnt_q <= CW'(1);
                        state_q    <= LOCKED;
                    end
                end
                LOCKED: begin
                    // Stay only on a locked beat that leaves budget; a bubble, unlock or full count releases.
                    if (bus.m_req[owner_q] && bus.m_lock[owner_q] && (int'(lock_cnt_q) + 1 < MAX_LOCK)) begin
                        lock_cnt_q <= lock_cnt_q + CW'(1);
                    end else begin
                        state_q    <= ARB;
                        lock_cnt_q <= '0;
                        rr_ptr_q   <= nxt(owner_q);
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

`ifdef ARB_CONFLICT_CNT_EN
    logic        conflict_d;
    logic [31:0] conflict_q;

    always_comb begin
        conflict_d = ($countones(bus.m_req) >= 2) ||
                     ((state_q == LOCKED) && ((bus.m_req & ~(NUM_REQ'(1) << owner_q)) != '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   conflict_q <= '0;
        else if (conflict_d && conflict_q != '1)   conflict_q <= conflict_q + 32'd1;
    end

    assign perf_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-scenario tasks check grants, a negedge
// scoreboard checks every read return against a behavioural memory.
module tb_mem_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef ARB_CONFLICT_CNT_EN
    logic [31:0] perf_conflict;
`endif

    mem_arbiter #(.NUM_REQ(N), .MAX_LOCK(8), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ARB_CONFLICT_CNT_EN
        ,
        .perf_conflict (perf_conflict)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] mem [0:1023];

    // Memory model: refilled with a known pattern while reset is high, 1-cycle read latency.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= (i == 'h80) ? 32'h1111_1111 : (32'hA500_0000 | 32'(i));
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wstrb[b]) mem[bus.mem_addr[11:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr[11:2]];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin : scoreboard
        logic [N-1:0] want;
        logic [31:0]  wd;
        want = '0;
        wd   = '0;
        if (rst) begin
            sbq.delete();
        end else begin
            if (sbq.size() != 0 && sbq[0].due == cyc) begin
                want = N'(1) << sbq[0].idx;
                wd   = sbq[0].data;
                void'(sbq.pop_front());
            end
            checks++;
            if (bus.m_rvalid !== want || (want != '0 && bus.m_rdata !== wd)) begin
                errors++;
                $display("FAIL sb_rvalid cyc %0d: got %b/%h want %b/%h", cyc, bus.m_rvalid, bus.m_rdata, want, wd);
            end
            for (int i = 0; i < N; i++)
                if (bus.m_req[i] && bus.m_gnt[i] && !bus.m_we[i])
                    sbq.push_back('{i, mem[bus.m_addr[i][11:2]], cyc + 1});
        end
    end

    task automatic idle();
        bus.m_req   = '0;
        bus.m_lock  = '0;
        bus.m_we    = '0;
        bus.m_wstrb = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step(output logic [N-1:0] g, output logic [N-1:0] rv);
        @(negedge clk);
        g  = bus.m_gnt;
        rv = bus.m_rvalid;
        @(posedge clk);
        #1;
    endtask

    // Single read by requester 1, leaving rr_ptr at 2.
    task automatic prime_ptr2();
        logic [N-1:0] g, rv;
        bus.m_req[1] = 1'b1; bus.m_addr[1] = 32'h44;
        step(g, rv);
        checks++;
        if (g !== 3'b010) begin errors++; $display("FAIL prime_gnt got %b want 010", g); end
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.m_req = '1; bus.m_lock = '0; bus.m_we = '0; bus.m_wstrb = '0; bus.m_addr = '0; bus.m_wdata = '0;
        #1;
        checks++; if (bus.m_gnt !== 3'b000)   begin errors++; $display("FAIL rst_gnt got %b want 000", bus.m_gnt); end
        checks++; if (bus.m_rvalid !== 3'b000) begin errors++; $display("FAIL rst_rvalid got %b want 000", bus.m_rvalid); end
        checks++; if (bus.m_rdata !== 32'h0)   begin errors++; $display("FAIL rst_rdata got %h want 0", bus.m_rdata); end
        checks++; if (bus.mem_en !== 1'b0)     begin errors++; $display("FAIL rst_mem_en got %b want 0", bus.mem_en); end
`ifdef ARB_CONFLICT_CNT_EN
        checks++; if (perf_conflict !== 32'h0) begin errors++; $display("FAIL rst_perf got %0d want 0", perf_conflict); end
`endif
        do_reset();
    endtask

    task automatic test_single_read();
        logic [N-1:0] g, rv;
        do_reset();
        bus.m_req[2] = 1'b1; bus.m_addr[2] = 32'h200;
        step(g, rv);
        checks++; if (g !== 3'b100) begin errors++; $display("FAIL single_gnt got %b want 100", g); end
        idle();
        @(negedge clk);
        checks++;
        if (bus.m_rvalid !== 3'b100 || bus.m_rdata !== 32'h1111_1111) begin
            errors++; $display("FAIL single_rdata got %b/%h want 100/11111111", bus.m_rvalid, bus.m_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g, rv;
        do_reset();
        bus.m_req = '1;
        bus.m_addr[0] = 32'h10; bus.m_addr[1] = 32'h20; bus.m_addr[2] = 32'h30;
        for (int k = 0; k < 6; k++) begin
            step(g, rv);
            checks++;
            if (g !== N'(1) << (k % 3)) begin errors++; $display("FAIL rr_gnt beat %0d got %b want %b", k, g, N'(1) << (k % 3)); end
            if (k > 0) begin
                checks++;
                if (rv !== N'(1) << ((k - 1) % 3)) begin errors++; $display("FAIL rr_rvalid beat %0d got %b want %b", k, rv, N'(1) << ((k - 1) % 3)); end
            end
        end
        idle();
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_lock_burst();
        logic [N-1:0] g, rv, want;
        int beats;
        do_reset();
        prime_ptr2();
        beats = 0;
        bus.m_req[0] = 1'b1; bus.m_addr[0] = 32'h40;
        bus.m_req[2] = 1'b1; bus.m_lock[2] = 1'b1; bus.m_addr[2] = 32'h200;
        for (int c = 0; c < 14; c++) begin
            step(g, rv);
            want = (c == 8 || c == 13) ? 3'b001 : 3'b100;
            checks++;
            if (g !== want) begin errors++; $display("FAIL lock_gnt cyc %0d got %b want %b", c, g, want); end
            if (g[2]) begin
                beats++;
                bus.m_addr[2] = 32'h200 + 32'(4 * beats);
                bus.m_lock[2] = (beats < 11);
                if (beats == 12) bus.m_req[2] = 1'b0;
            end
        end
        checks++; if (beats != 12) begin errors++; $display("FAIL lock_beats got %0d want 12", beats); end
        idle();
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_early_unlock();
        logic [N-1:0] g, rv, want;
        int beats;
        do_reset();
        prime_ptr2();
        beats = 0;
        bus.m_req[1] = 1'b1; bus.m_addr[1] = 32'h48;
        bus.m_req[2] = 1'b1; bus.m_lock[2] = 1'b1; bus.m_addr[2] = 32'h300;
        for (int c = 0; c < 4; c++) begin
            step(g, rv);
            want = (c < 3) ? 3'b100 : 3'b010;
            checks++;
            if (g !== want) begin errors++; $display("FAIL unlock_gnt cyc %0d got %b want %b", c, g, want); end
            if (g[2]) begin
                beats++;
                bus.m_lock[2] = (beats < 2);
                if (beats == 3) bus.m_req[2] = 1'b0;
            end
            if (g[1]) bus.m_req[1] = 1'b0;
        end
        // A fresh burst must get the full lock budget if the count was cleared.
        bus.m_req[0] = 1'b1; bus.m_addr[0] = 32'h50;
        bus.m_req[2] = 1'b1; bus.m_lock[2] = 1'b1; bus.m_addr[2] = 32'h304;
        for (int c = 0; c < 9; c++) begin
            step(g, rv);
            want = (c < 8) ? 3'b100 : 3'b001;
            checks++;
            if (g !== want) begin errors++; $display("FAIL relock_gnt cyc %0d got %b want %b", c, g, want); end
        end
        idle();
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [N-1:0] g, rv;
        do_reset();
        bus.m_req[1] = 1'b1; bus.m_we[1] = 1'b1; bus.m_wstrb[1] = 4'hF;
        bus.m_addr[1] = 32'h400; bus.m_wdata[1] = 32'hDEAD_BEEF;
        step(g, rv);
        checks++; if (g !== 3'b010) begin errors++; $display("FAIL wr_gnt got %b want 010", g); end
        idle();
        bus.m_req[0] = 1'b1; bus.m_addr[0] = 32'h400;
        step(g, rv);
        checks++; if (g !== 3'b001) begin errors++; $display("FAIL rd_gnt got %b want 001", g); end
        checks++; if (rv !== 3'b000) begin errors++; $display("FAIL wr_rvalid got %b want 000", rv); end
        idle();
        @(negedge clk);
        checks++;
        if (bus.m_rvalid !== 3'b001 || bus.m_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_rd_data got %b/%h want 001/deadbeef", bus.m_rvalid, bus.m_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        logic [N-1:0] g, rv;
        do_reset();
        prime_ptr2();
        bus.m_req[0] = 1'b1; bus.m_addr[0] = 32'h60;
        bus.m_req[2] = 1'b1; bus.m_lock[2] = 1'b1; bus.m_addr[2] = 32'h380;
        step(g, rv);
        step(g, rv);
        checks++; if (g !== 3'b100) begin errors++; $display("FAIL mid_gnt got %b want 100", g); end
        checks++; if (bus.m_rvalid !== 3'b100) begin errors++; $display("FAIL mid_pending got %b want 100", bus.m_rvalid); end
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.m_gnt !== 3'b000)    begin errors++; $display("FAIL mid_rst_gnt got %b want 000", bus.m_gnt); end
        checks++; if (bus.m_rvalid !== 3'b000) begin errors++; $display("FAIL mid_rst_rvalid got %b want 000", bus.m_rvalid); end
        checks++; if (bus.mem_en !== 1'b0)     begin errors++; $display("FAIL mid_rst_mem_en got %b want 0", bus.mem_en); end
        @(posedge clk);
        #1 rst = 1'b0;
        step(g, rv);
        checks++; if (g !== 3'b001) begin errors++; $display("FAIL post_rst_gnt got %b want 001", g); end
        idle();
        repeat (2) @(posedge clk); #1;
    endtask

    initial begin
        idle();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_burst();
        test_early_unlock();
        test_write_read();
        test_reset_mid_burst();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
